// File: rtl/alu_mult_sequencer_if.sv
// alu_mult_sequencer_if
//   Groups the request/response handshake of the multiplier and the
//   operand/opSel/result bus it shares with the execute-stage ALU.
//   Ports (seen from the sequencer, modport slave):
//     in : start, multiplicand, multiplier, aluResult, aluZero
//     out: busy, done, product, aluOperand1, aluOperand2, aluOpSel
//   modport master is the mirror image (requester plus ALU side).
interface alu_mult_sequencer_if #(
  parameter int data_width = 32,
  parameter int sel_width  = 4
);
  logic                  start;
  logic [data_width-1:0] multiplicand;
  logic [data_width-1:0] multiplier;
  logic                  busy;
  logic                  done;
  logic [data_width-1:0] product;
  logic [data_width-1:0] aluOperand1;
  logic [data_width-1:0] aluOperand2;
  logic [sel_width-1:0]  aluOpSel;
  logic [data_width-1:0] aluResult;
  logic                  aluZero;

  modport slave (
    input  start, multiplicand, multiplier, aluResult, aluZero,
    output busy, done, product, aluOperand1, aluOperand2, aluOpSel
  );

  modport master (
    output start, multiplicand, multiplier, aluResult, aluZero,
    input  busy, done, product, aluOperand1, aluOperand2, aluOpSel
  );
endinterface

// File: rtl/alu_mult_sequencer.sv
// alu_mult_sequencer
//   Shift-and-add unsigned multiplier that owns no arithmetic of its own:
//   every add and shift is issued to the shared ALU and the result is
//   captured on the following rising edge. Returns (A*B) mod 2^data_width.
//   Ports:
//     clk    : rising-edge clock
//     reset  : asynchronous, active-high; forces IDLE and clears product
//     mul_if : alu_mult_sequencer_if.slave (request/response + ALU bus)
module alu_mult_sequencer #(
  parameter int data_width = 32,
  parameter int sel_width  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  alu_mult_sequencer_if.slave   mul_if
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_ADD  = 3'd1;
  localparam logic [2:0] S_SHL  = 3'd2;
  localparam logic [2:0] S_SHR  = 3'd3;
  localparam logic [2:0] S_FIN  = 3'd4;

  localparam logic [sel_width-1:0] OP_ADD = sel_width'(4'b0000);
  localparam logic [sel_width-1:0] OP_SLL = sel_width'(4'b0111);
  localparam logic [sel_width-1:0] OP_SRL = sel_width'(4'b1000);

  localparam logic [data_width-1:0] ONE = {{(data_width-1){1'b0}}, 1'b1};

  logic [2:0]            r_state;
  logic [2:0]            w_state_next;
  logic [data_width-1:0] r_m;        // multiplicand, shifted left each bit
  logic [data_width-1:0] r_q;        // multiplier bits not yet consumed
  logic [data_width-1:0] r_acc;      // partial product
  logic [data_width-1:0] r_product;
  logic [data_width-1:0] w_op1;
  logic [data_width-1:0] w_op2;
  logic [sel_width-1:0]  w_sel;

  // ALU drive: quiet (0 + 0) whenever no operation is in flight.
  always_comb begin
    w_op1 = '0;
    w_op2 = '0;
    w_sel = OP_ADD;
    case (r_state)
      S_ADD: begin
        w_op1 = r_acc;
        w_op2 = r_m;
        w_sel = OP_ADD;
      end
      S_SHL: begin
        w_op1 = r_m;
        w_op2 = ONE;
        w_sel = OP_SLL;
      end
      S_SHR: begin
        w_op1 = r_q;
        w_op2 = ONE;
        w_sel = OP_SRL;
      end
      default: ;
    endcase
  end

  // After shifting Q right, the ALU's zero flag says no multiplier bits
  // remain, and result bit 0 decides whether the next step adds.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (mul_if.start) begin
          if (mul_if.multiplier == '0)
            w_state_next = S_FIN;
          else if (mul_if.multiplier[0])
            w_state_next = S_ADD;
          else
            w_state_next = S_SHL;
        end
      end
      S_ADD: w_state_next = S_SHL;
      S_SHL: w_state_next = S_SHR;
      S_SHR: begin
        if (mul_if.aluZero)
          w_state_next = S_FIN;
        else if (mul_if.aluResult[0])
          w_state_next = S_ADD;
        else
          w_state_next = S_SHL;
      end
      S_FIN:   w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_m       <= '0;
      r_q       <= '0;
      r_acc     <= '0;
      r_product <= '0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        S_IDLE: begin
          if (mul_if.start) begin
            r_m   <= mul_if.multiplicand;
            r_q   <= mul_if.multiplier;
            r_acc <= '0;
            // A zero multiplier skips straight to FIN with a zero product.
            if (mul_if.multiplier == '0)
              r_product <= '0;
          end
        end
        S_ADD: r_acc <= mul_if.aluResult;
        S_SHL: r_m   <= mul_if.aluResult;
        S_SHR: begin
          r_q <= mul_if.aluResult;
          if (mul_if.aluZero)
            r_product <= r_acc;
        end
        default: ;
      endcase
    end
  end

  assign mul_if.busy        = (r_state != S_IDLE);
  assign mul_if.done        = (r_state == S_FIN);
  assign mul_if.product     = r_product;
  assign mul_if.aluOperand1 = w_op1;
  assign mul_if.aluOperand2 = w_op2;
  assign mul_if.aluOpSel    = w_sel;

endmodule

// File: tb/tb_alu_mult_sequencer.sv
module tb_alu_mult_sequencer;
  localparam int DW = 32;
  localparam int SW = 4;
  localparam logic [3:0] ADD = 4'b0000;
  localparam logic [3:0] SLL = 4'b0111;
  localparam logic [3:0] SRL = 4'b1000;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  alu_mult_sequencer_if #(.data_width(DW), .sel_width(SW)) bus ();

  alu_mult_sequencer #(.data_width(DW), .sel_width(SW)) dut (
    .clk    (clk),
    .reset  (reset),
    .mul_if (bus)
  );

  // Combinational model of the shared ALU.
  logic [DW-1:0] alu_res;
  always_comb begin
    alu_res = '0;
    case (bus.aluOpSel)
      ADD:     alu_res = bus.aluOperand1 + bus.aluOperand2;
      SLL:     alu_res = bus.aluOperand1 << bus.aluOperand2;
      SRL:     alu_res = bus.aluOperand1 >> bus.aluOperand2;
      default: alu_res = '0;
    endcase
  end
  assign bus.aluResult = alu_res;
  assign bus.aluZero   = (alu_res == '0);

  int n_vec = 0;
  int n_err = 0;
  int bad_sel = 0;
  logic [DW-1:0] exp_q[$];
  logic [3:0]    sel_log[$];

  always @(negedge clk)
    if (bus.aluOpSel !== ADD && bus.aluOpSel !== SLL && bus.aluOpSel !== SRL)
      bad_sel++;

  function automatic int exp_latency(input logic [DW-1:0] b);
    int h = 0;
    int pc = 0;
    if (b == '0) return 1;
    for (int i = 0; i < DW; i++)
      if (b[i]) begin h = i; pc++; end
    return 2 * (h + 1) + pc + 1;
  endfunction

  task automatic start_op(input logic [DW-1:0] a, input logic [DW-1:0] b);
    @(negedge clk);
    bus.start = 1'b1;
    bus.multiplicand = a;
    bus.multiplier = b;
    exp_q.push_back(a * b);
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Called in cycle 1 after the start edge; returns the cycle done was seen.
  task automatic wait_done(output int cyc);
    cyc = 1;
    sel_log.delete();
    while (bus.done !== 1'b1 && cyc < 200) begin
      sel_log.push_back(bus.aluOpSel);
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_mult(input logic [DW-1:0] a, input logic [DW-1:0] b, input string name);
    int cyc;
    logic [DW-1:0] exp_p;
    start_op(a, b);
    wait_done(cyc);
    exp_p = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
    n_vec++;
    if (cyc !== exp_latency(b)) begin
      n_err++;
      $display("FAIL %s latency: got %0d want %0d", name, cyc, exp_latency(b));
    end
    n_vec++;
    if (bus.product !== exp_p) begin
      n_err++;
      $display("FAIL %s product: got %h want %h", name, bus.product, exp_p);
    end
    n_vec++;
    if (bus.busy !== 1'b1 || bus.aluOpSel !== ADD || bus.aluOperand1 !== '0 || bus.aluOperand2 !== '0) begin
      n_err++;
      $display("FAIL %s fin_state: busy=%b sel=%h op1=%h op2=%h want 1/0/0/0", name,
               bus.busy, bus.aluOpSel, bus.aluOperand1, bus.aluOperand2);
    end
    @(negedge clk);
    n_vec++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.product !== exp_p) begin
      n_err++;
      $display("FAIL %s idle_after: busy=%b done=%b product=%h want 0/0/%h", name,
               bus.busy, bus.done, bus.product, exp_p);
    end
    $display("%s: %h * %h -> %h in %0d cycles", name, a, b, bus.product, cyc);
  endtask

  task automatic test_reset();
    #1;
    n_vec++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.product !== '0 ||
        bus.aluOpSel !== ADD || bus.aluOperand1 !== '0 || bus.aluOperand2 !== '0) begin
      n_err++;
      $display("FAIL reset_state: busy=%b done=%b product=%h sel=%h op1=%h op2=%h want all 0",
               bus.busy, bus.done, bus.product, bus.aluOpSel, bus.aluOperand1, bus.aluOperand2);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    $display("reset: state checked");
  endtask

  task automatic test_basic();
    logic [3:0] exp_seq[6];
    int bad = 0;
    exp_seq = '{ADD, SLL, SRL, ADD, SLL, SRL};
    test_mult(32'd5, 32'd3, "basic_5x3");
    if (sel_log.size() != 6) bad++;
    else for (int i = 0; i < 6; i++) if (sel_log[i] !== exp_seq[i]) bad++;
    n_vec++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL basic_opsel_seq: got %0d ops (%0d wrong) want ADD,SLL,SRL,ADD,SLL,SRL",
               sel_log.size(), bad);
    end
  endtask

  task automatic test_zero_multiplier();
    test_mult(32'h1234, 32'h0, "zero_mult");
    n_vec++;
    if (sel_log.size() != 0) begin
      n_err++;
      $display("FAIL zero_mult_no_ops: got %0d ops want 0", sel_log.size());
    end
  endtask

  task automatic test_boundaries();
    test_mult(32'd7, 32'h8000_0000, "msb_only");
    test_mult(32'hFFFF_FFFF, 32'hFFFF_FFFF, "all_ones");
  endtask

  task automatic test_random();
    for (int i = 0; i < 4; i++)
      test_mult($urandom, $urandom_range(1, 32'h0000_FFFF), "random");
  endtask

  task automatic test_back_to_back();
    int cyc;
    logic [DW-1:0] exp_p;
    start_op(32'd3, 32'd5);
    cyc = 1;
    while (bus.done !== 1'b1 && cyc < 200) begin
      if (cyc == 2) begin
        bus.start = 1'b1;
        bus.multiplicand = 32'd9;
        bus.multiplier = 32'd9;
      end
      @(negedge clk);
      cyc++;
    end
    exp_p = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
    n_vec++;
    if (cyc !== exp_latency(32'd5) || bus.product !== exp_p) begin
      n_err++;
      $display("FAIL busy_start_ignored: cycles=%0d product=%h want %0d/%h",
               cyc, bus.product, exp_latency(32'd5), exp_p);
    end
    $display("busy_start: 3*5 -> %h in %0d cycles", bus.product, cyc);
    // start is still high: the IDLE cycle after FIN accepts 9*9.
    exp_q.push_back(32'd81);
    @(negedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(cyc);
    exp_p = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
    n_vec++;
    if (cyc !== exp_latency(32'd9) || bus.product !== exp_p) begin
      n_err++;
      $display("FAIL back_to_back: cycles=%0d product=%h want %0d/%h",
               cyc, bus.product, exp_latency(32'd9), exp_p);
    end
    $display("back_to_back: 9*9 -> %h in %0d cycles", bus.product, cyc);
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int done_seen = 0;
    start_op(32'd5, 32'd3);
    @(negedge clk);
    @(negedge clk);
    n_vec++;
    if (bus.busy !== 1'b1) begin
      n_err++;
      $display("FAIL reset_mid_busy_before: got %b want 1", bus.busy);
    end
    reset = 1'b1;
    #1;
    exp_q.delete();
    n_vec++;
    if (bus.busy !== 1'b0 || bus.product !== '0 || bus.aluOpSel !== ADD ||
        bus.aluOperand1 !== '0 || bus.aluOperand2 !== '0) begin
      n_err++;
      $display("FAIL reset_mid_outputs: busy=%b product=%h sel=%h op1=%h op2=%h want 0",
               bus.busy, bus.product, bus.aluOpSel, bus.aluOperand1, bus.aluOperand2);
    end
    repeat (2) begin
      @(negedge clk);
      if (bus.done === 1'b1) done_seen++;
    end
    reset = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (bus.done === 1'b1) done_seen++;
    end
    n_vec++;
    if (done_seen != 0 || bus.product !== '0 || bus.busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_mid_after: done_pulses=%0d product=%h busy=%b want 0/0/0",
               done_seen, bus.product, bus.busy);
    end
    $display("reset_mid: done_pulses=%0d product=%h", done_seen, bus.product);
  endtask

  task automatic test_opsel_legal();
    n_vec++;
    if (bad_sel != 0) begin
      n_err++;
      $display("FAIL opsel_legal: got %0d illegal cycles want 0", bad_sel);
    end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.multiplicand = '0;
    bus.multiplier = '0;
    test_reset();
    test_basic();
    test_zero_multiplier();
    test_boundaries();
    test_random();
    test_back_to_back();
    test_reset_mid();
    test_opsel_legal();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
